branch_target_buffer: RTL and testbench

Parametrised direct-mapped branch target buffer with 2-bit saturating direction counters and an optional return-address stack. Sits beside the fetch stage of the five-stage pipeline. Fetch reads a next-PC prediction combinationally from the IF PC. The EX stage writes resolved outcomes back, so taken branches, `j`/`jal` and `jr` stop costing a flush once they are trained.

---
 rtl/bp_pkg.sv | 25 ++
 rtl/bp_ras.sv | 48 ++++
 rtl/branch_target_buffer.sv | 125 ++++++++++++
 tb/tb_branch_target_buffer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared branch-prediction types: control-kind encoding, counter constants
// and the 2-bit saturating counter step used by branch_target_buffer.
package bp_pkg;

  typedef enum logic [1:0] {
    BR   = 2'd0,
    JMP  = 2'd1,
    CALL = 2'd2,
    RET  = 2'd3
  } kind_e;

  localparam logic [1:0] CTR_WEAK_T   = 2'd2;
  localparam logic [1:0] CTR_STRONG_T = 2'd3;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && ctr != 2'd3)
      nxt = ctr + 2'd1;
    else if (!taken && ctr != 2'd0)
      nxt = ctr - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/bp_ras.sv
// Circular return-address stack: a push on a full stack overwrites the oldest
// entry, a pop on an empty stack is ignored. Used only under BTB_RAS_EN.
module bp_ras #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     push_data,
  output logic [W-1:0]     top,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  // wr_ptr_q always names the next free slot; the pointer wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (push) begin
      wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (count_q != CNT_W'(DEPTH))
        count_q <= count_q + CNT_W'(1);
    end else if (pop && count_q != '0) begin
      wr_ptr_q <= wr_ptr_q - PTR_W'(1);
      count_q  <= count_q - CNT_W'(1);
    end
  end

  // NOTE: storage arrays carry no reset; the count alone says which slots are live.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_q] <= push_data;
  end

  assign top   = mem[wr_ptr_q - PTR_W'(1)];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit direction counters beside fetch.
// Define BTB_RAS_EN to add a return-address stack that predicts kind-3 entries.
module branch_target_buffer
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES   = 16,
  parameter int unsigned PC_W      = 32,
  parameter int unsigned RAS_DEPTH = 4,
  localparam int unsigned IDX_W = $clog2(ENTRIES),
  localparam int unsigned TAG_W = PC_W - 2 - IDX_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_next_pc,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic [1:0]      upd_kind,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  input  logic            flush_all
);

  logic [ENTRIES-1:0] valid_q;
  logic [1:0]         ctr_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [PC_W-3:0]    target_q [ENTRIES];
  kind_e              kind_q   [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_hit, up_taken, do_upd;
  kind_e            up_kind;
  logic [PC_W-1:0]  lk_target;
  logic             ras_use;
  logic [PC_W-1:0]  ras_top;

  assign lk_idx = if_pc[IDX_W+1:2];
  assign lk_tag = if_pc[PC_W-1:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[PC_W-1:IDX_W+2];

  assign up_kind  = kind_e'(upd_kind);
  assign up_taken = (up_kind != BR) || upd_taken;
  assign up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign do_upd   = upd_valid && !flush_all;

`ifdef BTB_RAS_EN
  logic                           ras_empty;
  logic [$clog2(RAS_DEPTH+1)-1:0] ras_count;
  logic                           unused_bits;

  bp_ras #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (do_upd && up_kind == CALL),
    .pop       (do_upd && up_kind == RET),
    .push_data (upd_pc + PC_W'(4)),
    .top       (ras_top),
    .empty     (ras_empty),
    .count     (ras_count)
  );

  assign ras_use     = !ras_empty;
  assign unused_bits = ^{if_pc[1:0], upd_target[1:0], ras_count};
`else
  logic unused_bits;

  assign ras_use     = 1'b0;
  assign ras_top     = '0;
  assign unused_bits = ^{if_pc[1:0], upd_pc[1:0], upd_target[1:0]} ^ (RAS_DEPTH == 0);
`endif

  // Lookup reads only registered state, so a same-cycle update is not bypassed.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    pred_hit     = 1'b0;
    pred_taken   = 1'b0;
    lk_target    = {target_q[lk_idx], 2'b00};
    pred_next_pc = if_pc + PC_W'(4);
    if (valid_q[lk_idx] && tag_q[lk_idx] == lk_tag) begin
      pred_hit   = 1'b1;
      pred_taken = (kind_q[lk_idx] != BR) || ctr_q[lk_idx][1];
      if (kind_q[lk_idx] == RET && ras_use)
        lk_target = ras_top;
    end
    if (pred_taken)
      pred_next_pc = lk_target;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++)
        ctr_q[i] <= '0;
    end else if (flush_all) begin
      valid_q <= '0;
    end else if (upd_valid) begin
      if (up_hit) begin
        if (up_kind == BR)
          ctr_q[up_idx] <= ctr_next(ctr_q[up_idx], upd_taken);
      end else if (up_taken) begin
        valid_q[up_idx] <= 1'b1;
        ctr_q[up_idx]   <= (up_kind == BR) ? CTR_WEAK_T : CTR_STRONG_T;
      end
    end
  end

  // Payload is written on every taken update; on a hit the tag rewrite is a no-op.
  always_ff @(posedge clk) begin
    if (do_upd && up_taken) begin
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= upd_target[PC_W-1:2];
      kind_q[up_idx]   <= up_kind;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer against a table-level reference
// model; the return-stack model is active when BTB_RAS_EN is defined.
module tb_branch_target_buffer;

  localparam int ENTRIES   = 16;
  localparam int IDX_W     = 4;
  localparam int RAS_DEPTH = 4;
`ifdef BTB_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_next_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [1:0]  upd_kind;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        flush_all;

  int n_cmp = 0;
  int n_bad = 0;

  branch_target_buffer #(
    .ENTRIES   (ENTRIES),
    .PC_W      (32),
    .RAS_DEPTH (RAS_DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .if_pc        (if_pc),
    .pred_hit     (pred_hit),
    .pred_taken   (pred_taken),
    .pred_next_pc (pred_next_pc),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_kind     (upd_kind),
    .upd_taken    (upd_taken),
    .upd_target   (upd_target),
    .flush_all    (flush_all)
  );

  always #5 clk = ~clk;

  // Reference model: one record per table slot plus a queue for the return stack.
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_kind   [ENTRIES];
  int          m_ctr    [ENTRIES];
  logic [31:0] ras_q [$];

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int unsigned tag_of(logic [31:0] pc);
    return int'(pc >> (2 + IDX_W));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 0;
    end
    ras_q.delete();
  endtask

  task automatic model_update(logic [31:0] pc, int kind, bit taken, logic [31:0] target);
    int i;
    bit tk, hit;
    i   = idx_of(pc);
    tk  = (kind != 0) || taken;
    hit = m_valid[i] && m_tag[i] == tag_of(pc);
    if (hit) begin
      if (kind == 0) begin
        if (taken && m_ctr[i] < 3) m_ctr[i]++;
        else if (!taken && m_ctr[i] > 0) m_ctr[i]--;
      end
      if (tk) begin
        m_target[i] = target & 32'hFFFF_FFFC;
        m_kind[i]   = kind;
      end
    end else if (tk) begin
      m_valid[i]  = 1'b1;
      m_tag[i]    = tag_of(pc);
      m_target[i] = target & 32'hFFFF_FFFC;
      m_kind[i]   = kind;
      m_ctr[i]    = (kind == 0) ? 2 : 3;
    end
    if (RAS_EN) begin
      if (kind == 2) begin
        ras_q.push_back(pc + 32'd4);
        if (ras_q.size() > RAS_DEPTH) void'(ras_q.pop_front());
      end else if (kind == 3 && ras_q.size() > 0) begin
        void'(ras_q.pop_back());
      end
    end
  endtask

  // Returns {hit, taken, next_pc}.
  function automatic logic [33:0] model_predict(logic [31:0] pc);
    int i;
    bit hit, tk;
    logic [31:0] nxt;
    i   = idx_of(pc);
    hit = m_valid[i] && m_tag[i] == tag_of(pc);
    tk  = hit && (m_kind[i] != 0 || m_ctr[i] >= 2);
    nxt = pc + 32'd4;
    if (tk) nxt = (m_kind[i] == 3 && RAS_EN && ras_q.size() > 0) ? ras_q[$] : m_target[i];
    return {hit, tk, nxt};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (flush_all) begin
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    end else if (upd_valid) begin
      model_update(upd_pc, int'(upd_kind), upd_taken, upd_target);
    end
    #1;
  endtask

  task automatic send_upd(logic [31:0] pc, logic [1:0] kind, logic taken, logic [31:0] target);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_kind   = kind;
    upd_taken  = taken;
    upd_target = target;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [33:0] e;
    reset = 1'b1; if_pc = 32'h100; upd_valid = 1'b0; upd_pc = '0; upd_kind = '0;
    upd_taken = 1'b0; upd_target = '0; flush_all = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    n_cmp++;
    if ({pred_hit, pred_taken, pred_next_pc} !== {2'b00, 32'h104}) begin
      n_bad++;
      $display("FAIL reset_0x100: got hit=%0b taken=%0b next=%h, want 0 0 00000104", pred_hit, pred_taken, pred_next_pc);
    end
    if_pc = 32'hFFFF_FFFC; #1;
    e = model_predict(if_pc);
    n_cmp++;
    if ({pred_hit, pred_taken, pred_next_pc} !== e) begin
      n_bad++;
      $display("FAIL reset_wrap: got %h want %h", {pred_hit, pred_taken, pred_next_pc}, e);
    end
  endtask

  task automatic test_counter();
    logic [33:0] e;
    send_upd(32'h100, 2'd0, 1'b1, 32'h40);
    if_pc = 32'h100; #1;
    e = model_predict(if_pc);
    n_cmp++;
    if ({pred_hit, pred_taken, pred_next_pc} !== e) begin
      n_bad++;
      $display("FAIL alloc_taken: got %h want %h", {pred_hit, pred_taken, pred_next_pc}, e);
    end
    for (int k = 0; k < 3; k++) begin
      send_upd(32'h100, 2'd0, k == 2, 32'h40);
      #1;
      e = model_predict(if_pc);
      n_cmp++;
      if ({pred_hit, pred_taken, pred_next_pc} !== e) begin
        n_bad++;
        $display("FAIL counter_step%0d: got %h want %h", k, {pred_hit, pred_taken, pred_next_pc}, e);
      end
    end
  endtask

  task automatic test_alias();
    logic [33:0] e;
    send_upd(32'h100, 2'd1, 1'b0, 32'h700);
    send_upd(32'h140, 2'd1, 1'b0, 32'h740);
    for (int k = 0; k < 2; k++) begin
      if_pc = (k == 0) ? 32'h100 : 32'h140; #1;
      e = model_predict(if_pc);
      n_cmp++;
      if ({pred_hit, pred_taken, pred_next_pc} !== e) begin
        n_bad++;
        $display("FAIL alias_%h: got %h want %h", if_pc, {pred_hit, pred_taken, pred_next_pc}, e);
      end
    end
  endtask

  task automatic test_same_cycle_and_flush();
    logic [33:0] e;
    if_pc = 32'h200; upd_valid = 1'b1; upd_pc = 32'h200; upd_kind = 2'd1;
    upd_taken = 1'b0; upd_target = 32'h500; #1;
    e = model_predict(if_pc);
    n_cmp++;
    if ({pred_hit, pred_taken, pred_next_pc} !== e) begin
      n_bad++;
      $display("FAIL same_cycle_old: got %h want %h", {pred_hit, pred_taken, pred_next_pc}, e);
    end
    tick();
    upd_valid = 1'b0; #1;
    e = model_predict(if_pc);
    n_cmp++;
    if ({pred_hit, pred_taken, pred_next_pc} !== e) begin
      n_bad++;
      $display("FAIL same_cycle_new: got %h want %h", {pred_hit, pred_taken, pred_next_pc}, e);
    end
    flush_all = 1'b1;
    send_upd(32'h304, 2'd1, 1'b0, 32'h900);
    flush_all = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if_pc = (k == 0) ? 32'h200 : 32'h304; #1;
      e = model_predict(if_pc);
      n_cmp++;
      if ({pred_hit, pred_taken, pred_next_pc} !== e) begin
        n_bad++;
        $display("FAIL flush_%h: got %h want %h", if_pc, {pred_hit, pred_taken, pred_next_pc}, e);
      end
    end
  endtask

  task automatic test_ras();
    logic [33:0] e;
    send_upd(32'h88, 2'd3, 1'b0, 32'h998);
    for (int k = 1; k <= 5; k++) send_upd(32'h10 * k, 2'd2, 1'b0, 32'h300);
    if_pc = 32'h88;
    for (int k = 0; k < 5; k++) begin
      #1;
      e = model_predict(if_pc);
      n_cmp++;
      if ({pred_hit, pred_taken, pred_next_pc} !== e) begin
        n_bad++;
        $display("FAIL ras_pop%0d: got %h want %h", k, {pred_hit, pred_taken, pred_next_pc}, e);
      end
      send_upd(32'h88, 2'd3, 1'b0, 32'h998);
    end
  endtask

  task automatic test_random();
    logic [33:0] e;
    logic [31:0] pool [8];
    pool = '{32'h100, 32'h140, 32'h104, 32'h208, 32'hFFFF_FFFC, 32'h88, 32'h3C, 32'h7C};
    for (int c = 0; c < 1500; c++) begin
      if_pc      = ($urandom_range(0, 7) == 0) ? ($urandom() & 32'hFFFF_FFFC) : pool[$urandom_range(0, 7)];
      upd_valid  = $urandom_range(0, 1) == 1;
      upd_pc     = pool[$urandom_range(0, 7)];
      upd_kind   = 2'($urandom_range(0, 3));
      upd_taken  = $urandom_range(0, 1) == 1;
      upd_target = $urandom();
      flush_all  = $urandom_range(0, 40) == 0;
      #1;
      e = model_predict(if_pc);
      n_cmp++;
      if ({pred_hit, pred_taken, pred_next_pc} !== e) begin
        n_bad++;
        $display("FAIL random_c%0d pc=%h: got %h want %h", c, if_pc, {pred_hit, pred_taken, pred_next_pc}, e);
      end
      if ($urandom_range(0, 250) == 0) begin
        reset = 1'b1; #1;
        model_reset();
        e = model_predict(if_pc);
        n_cmp++;
        if ({pred_hit, pred_taken, pred_next_pc} !== e) begin
          n_bad++;
          $display("FAIL mid_reset_c%0d: got %h want %h", c, {pred_hit, pred_taken, pred_next_pc}, e);
        end
        reset = 1'b0;
        upd_valid = 1'b0; flush_all = 1'b0;
      end
      tick();
    end
    upd_valid = 1'b0; flush_all = 1'b0;
  endtask

  initial begin
    test_reset();
    test_counter();
    test_alias();
    test_same_cycle_and_flush();
    test_ras();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
